vga_timing_controller: RTL and testbench

//   Sequences the VGA raster for the oscilloscope display. Owns the horizontal and vertical

---
 rtl/vga_timing_controller.sv | 128 ++++++++++++
 tb/tb_vga_timing_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_controller.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_controller
//  Brief    : VGA raster sequencer. Generates the horizontal/vertical pixel
//             counters, registered hsync/vsync/video_on, line/frame pulses,
//             the vertical phase state and the vblank-aligned buffer swap ack.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_controller #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic        clk_25MHz,
   input  logic        rst_n,
   input  logic        run,
   input  logic        swap_req,
   output logic        swap_ack,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic [15:0] pixel_x,
   output logic [15:0] pixel_y,
   output logic        line_end,
   output logic        frame_start,
   output logic [1:0]  v_state
);

   // Raster geometry as 16-bit constants.
   localparam logic [15:0] c_h_active   = 16'(H_ACTIVE);
   localparam logic [15:0] c_h_last     = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [15:0] c_hs_start   = 16'(H_ACTIVE + H_FP);
   localparam logic [15:0] c_hs_end     = 16'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [15:0] c_v_active   = 16'(V_ACTIVE);
   localparam logic [15:0] c_v_last     = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [15:0] c_vs_start   = 16'(V_ACTIVE + V_FP);
   localparam logic [15:0] c_vs_end     = 16'(V_ACTIVE + V_FP + V_SYNC);

   // Vertical phase encoding (visible on the v_state port).
   localparam logic [1:0] ST_ACTIVE = 2'd0;
   localparam logic [1:0] ST_FRONT  = 2'd1;
   localparam logic [1:0] ST_SYNC   = 2'd2;
   localparam logic [1:0] ST_BACK   = 2'd3;

   // running: the previous cycle was a counting cycle. A cycle that follows
   // reset or run=0 shows (0,0) with live outputs instead of incrementing,
   // so every restart begins with a full frame and a frame_start pulse.
   logic        running;
   logic        live;
   logic        line_wrap;
   logic [15:0] h_next;
   logic [15:0] v_next;
   logic [1:0]  state_next;
   logic        hs_on;
   logic        vs_on;

   // Next raster position; counters collapse to (0,0) whenever not counting.
   always_comb begin
      h_next    = 16'd0;
      v_next    = 16'd0;
      live      = run;
      line_wrap = 1'b0;
      if (run && running) begin
         if (pixel_x == c_h_last) begin
            line_wrap = 1'b1;
            v_next    = (pixel_y == c_v_last) ? 16'd0 : pixel_y + 16'd1;
         end else begin
            h_next = pixel_x + 16'd1;
            v_next = pixel_y;
         end
      end
   end

   // Vertical phase FSM: advances only on the line wrap that moves v_cnt.
   always_comb begin
      state_next = v_state;
      if (!(run && running)) begin
         state_next = ST_ACTIVE;
      end else if (line_wrap) begin
         case (v_state)
            ST_ACTIVE: if (v_next == c_v_active) state_next = ST_FRONT;
            ST_FRONT:  if (v_next == c_vs_start) state_next = ST_SYNC;
            ST_SYNC:   if (v_next == c_vs_end)   state_next = ST_BACK;
            default:   if (v_next == 16'd0)      state_next = ST_ACTIVE;
         endcase
      end
   end

   assign hs_on = live && (h_next >= c_hs_start) && (h_next < c_hs_end);
   assign vs_on = live && (v_next >= c_vs_start) && (v_next < c_vs_end);

   // All outputs are registered from the next position so they line up
   // with pixel_x/pixel_y in the same cycle.
   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         running     <= 1'b0;
         pixel_x     <= 16'd0;
         pixel_y     <= 16'd0;
         v_state     <= ST_ACTIVE;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         video_on    <= 1'b0;
         line_end    <= 1'b0;
         frame_start <= 1'b0;
         swap_ack    <= 1'b0;
      end else begin
         running     <= run;
         pixel_x     <= h_next;
         pixel_y     <= v_next;
         v_state     <= state_next;
         hsync       <= hs_on ? SYNC_POL : ~SYNC_POL;
         vsync       <= vs_on ? SYNC_POL : ~SYNC_POL;
         video_on    <= live && (h_next < c_h_active) && (v_next < c_v_active);
         line_end    <= live && (h_next == c_h_last);
         frame_start <= live && (h_next == 16'd0) && (v_next == 16'd0);
         // (0, V_ACTIVE) occurs once per frame, so this grants at most once.
         swap_ack    <= live && swap_req && (h_next == 16'd0) && (v_next == c_v_active);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_controller
//  Brief    : Self-checking bench. Instance A uses the 640x480 geometry for
//             line-level checks; instance B uses a small raster with
//             active-high syncs so whole frames fit in a short run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_controller;

   typedef struct packed {
      logic        ack;
      logic        hs;
      logic        vs;
      logic        von;
      logic [15:0] x;
      logic [15:0] y;
      logic        le;
      logic        fs;
      logic [1:0]  st;
   } out_t;

   typedef struct {
      int          t;
      logic [15:0] x;
      logic [15:0] y;
      logic        hs;
      logic        von;
      logic        le;
      logic        fs;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic run_a = 1'b1, req_a = 1'b0;
   logic run_b = 1'b1, req_b = 1'b0;

   logic ack_a, hs_a, vs_a, von_a, le_a, fs_a;
   logic ack_b, hs_b, vs_b, von_b, le_b, fs_b;
   logic [15:0] px_a, py_a, px_b, py_b;
   logic [1:0]  st_a, st_b;
   out_t got_a, got_b;

   int checks = 0;
   int errors = 0;

   // Reference model state: live flag, clocks since the first running cycle,
   // and the swap request as seen at the last clock edge.
   bit ma_live = 0, mb_live = 0;
   int ma_t = 0, mb_t = 0;
   bit ma_req = 0, mb_req = 0;

   always #10 clk = ~clk;

   vga_timing_controller dut_a (
      .clk_25MHz(clk), .rst_n(rst_n), .run(run_a), .swap_req(req_a),
      .swap_ack(ack_a), .hsync(hs_a), .vsync(vs_a), .video_on(von_a),
      .pixel_x(px_a), .pixel_y(py_a), .line_end(le_a), .frame_start(fs_a),
      .v_state(st_a));

   vga_timing_controller #(
      .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_ACTIVE(30), .V_FP(3), .V_SYNC(2), .V_BP(5), .SYNC_POL(1'b1)
   ) dut_b (
      .clk_25MHz(clk), .rst_n(rst_n), .run(run_b), .swap_req(req_b),
      .swap_ack(ack_b), .hsync(hs_b), .vsync(vs_b), .video_on(von_b),
      .pixel_x(px_b), .pixel_y(py_b), .line_end(le_b), .frame_start(fs_b),
      .v_state(st_b));

   assign got_a = {ack_a, hs_a, vs_a, von_a, px_a, py_a, le_a, fs_a, st_a};
   assign got_b = {ack_b, hs_b, vs_b, von_b, px_b, py_b, le_b, fs_b, st_b};

   // Expected outputs from the raster rules: position is a plain division of
   // elapsed running clocks by the line and frame lengths.
   function automatic out_t model_out(int ha, int hf, int hsw, int hb,
                                      int va, int vf, int vsw, int vb,
                                      bit pol, bit live, int t, bit req);
      out_t o;
      int ht, vt, x, y;
      ht = ha + hf + hsw + hb;
      vt = va + vf + vsw + vb;
      o = '0;
      o.hs = ~pol;
      o.vs = ~pol;
      if (!live) return o;
      x = t % ht;
      y = (t / ht) % vt;
      o.x   = 16'(x);
      o.y   = 16'(y);
      o.hs  = (x >= ha + hf && x < ha + hf + hsw) ? pol : ~pol;
      o.vs  = (y >= va + vf && y < va + vf + vsw) ? pol : ~pol;
      o.von = (x < ha) && (y < va);
      o.le  = (x == ht - 1);
      o.fs  = (x == 0) && (y == 0);
      o.ack = req && (x == 0) && (y == va);
      o.st  = (y < va) ? 2'd0 : (y < va + vf) ? 2'd1 : (y < va + vf + vsw) ? 2'd2 : 2'd3;
      return o;
   endfunction

   // Model time base for both instances.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma_live <= 0; ma_t <= 0; ma_req <= 0;
         mb_live <= 0; mb_t <= 0; mb_req <= 0;
      end else begin
         ma_req <= req_a;
         mb_req <= req_b;
         if (!run_a) begin ma_live <= 0; ma_t <= 0; end
         else if (!ma_live) begin ma_live <= 1; ma_t <= 0; end
         else ma_t <= ma_t + 1;
         if (!run_b) begin mb_live <= 0; mb_t <= 0; end
         else if (!mb_live) begin mb_live <= 1; mb_t <= 0; end
         else mb_t <= mb_t + 1;
      end
   end

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (time %0t)", nm, got, exp, $time);
      end
   endtask

   // Advance one cycle and compare both instances with the model.
   task automatic step();
      out_t ea, eb;
      @(negedge clk);
      ea = model_out(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, ma_live, ma_t, ma_req);
      eb = model_out(40, 4, 8, 4, 30, 3, 2, 5, 1'b1, mb_live, mb_t, mb_req);
      check("model_a", 64'(got_a), 64'(ea));
      check("model_b", 64'(got_b), 64'(eb));
   endtask

   task automatic wait_b(input int x, input int y, input int limit, input string nm);
      int n;
      n = 0;
      while (!(px_b == 16'(x) && py_b == 16'(y)) && n < limit) begin
         step();
         n++;
      end
      check(nm, 64'(px_b == 16'(x) && py_b == 16'(y)), 64'd1);
   endtask

   vec_t vec[12];
   out_t rst_a, rst_b;

   initial begin
      int idx, n, acks, vcnt, vscnt, extra_fs;
      bit found;

      vec[0]  = '{0,    16'd0,   16'd0, 1'b1, 1'b1, 1'b0, 1'b1};
      vec[1]  = '{639,  16'd639, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0};
      vec[2]  = '{640,  16'd640, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      vec[3]  = '{655,  16'd655, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      vec[4]  = '{656,  16'd656, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vec[5]  = '{751,  16'd751, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vec[6]  = '{752,  16'd752, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      vec[7]  = '{798,  16'd798, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      vec[8]  = '{799,  16'd799, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0};
      vec[9]  = '{800,  16'd0,   16'd1, 1'b1, 1'b1, 1'b0, 1'b0};
      vec[10] = '{1456, 16'd656, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      vec[11] = '{1599, 16'd799, 16'd1, 1'b1, 1'b0, 1'b1, 1'b0};

      rst_a = '0; rst_a.hs = 1'b1; rst_a.vs = 1'b1;
      rst_b = '0;

      // Reset held, then released with run=1.
      repeat (3) step();
      check("reset_a", 64'(got_a), 64'(rst_a));
      check("reset_b", 64'(got_b), 64'(rst_b));
      rst_n = 1'b1;

      // Line-level vectors on the 640x480 instance.
      idx = 0;
      for (int t = 0; t <= 1600; t++) begin
         step();
         while (idx < 12 && vec[idx].t == t) begin
            check($sformatf("vec%0d", idx),
                  {px_a, py_a, hs_a, von_a, le_a, fs_a},
                  {vec[idx].x, vec[idx].y, vec[idx].hs, vec[idx].von, vec[idx].le, vec[idx].fs});
            idx++;
         end
      end
      check("vec_all_applied", 64'(idx), 64'd12);

      // Whole frame on the small instance: period, active and vsync counts.
      n = 0;
      while (!fs_b && n < 3000) begin step(); n++; end
      check("frame_start_seen", 64'(fs_b), 64'd1);
      vcnt = 0; vscnt = 0; extra_fs = 0;
      for (int i = 0; i < 2240; i++) begin
         if (i > 0) begin
            step();
            if (fs_b) extra_fs++;
         end
         if (von_b) vcnt++;
         if (vs_b) vscnt++;
         if (px_b == 16'd39 && py_b == 16'd29) check("von_39_29", 64'(von_b), 64'd1);
         if (px_b == 16'd40 && py_b == 16'd0)  check("von_40_0", 64'(von_b), 64'd0);
         if (px_b == 16'd0 && py_b == 16'd30)  check("von_0_30", 64'(von_b), 64'd0);
      end
      step();
      check("frame_period", 64'(fs_b), 64'd1);
      check("frame_no_early_fs", 64'(extra_fs), 64'd0);
      check("video_cycles", 64'(vcnt), 64'd1200);
      check("vsync_cycles", 64'(vscnt), 64'd112);

      // Swap request raised mid-frame and held until acknowledged.
      wait_b(0, 10, 3000, "reach_0_10");
      req_b = 1'b1;
      found = 0; n = 0;
      while (!found && n < 3000) begin step(); n++; found = ack_b; end
      check("swap_ack_seen", 64'(found), 64'd1);
      check("swap_ack_pos", {px_b, py_b}, {16'd0, 16'd30});
      req_b = 1'b0;
      acks = 0;
      for (int i = 0; i < 2300; i++) begin step(); if (ack_b) acks++; end
      check("no_ack_after_drop", 64'(acks), 64'd0);

      // Request raised just after the grant cycle waits a whole frame.
      wait_b(5, 30, 3000, "reach_5_30");
      req_b = 1'b1;
      found = 0; n = 0;
      while (!found && n < 3000) begin step(); n++; found = ack_b; end
      check("late_ack_seen", 64'(found), 64'd1);
      check("late_ack_pos", {px_b, py_b}, {16'd0, 16'd30});
      check("late_ack_delay", 64'(n), 64'd2235);
      req_b = 1'b0;

      // run dropped mid-frame, then restored.
      wait_b(20, 15, 3000, "reach_20_15");
      run_b = 1'b0;
      step();
      check("run0_state", 64'(got_b), 64'(rst_b));
      repeat (4) step();
      run_b = 1'b1;
      step();
      check("run1_first", {fs_b, von_b, px_b, py_b, st_b}, {1'b1, 1'b1, 16'd0, 16'd0, 2'd0});

      // Asynchronous reset pulse between clock edges.
      wait_b(7, 12, 3000, "reach_7_12");
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_a", 64'(got_a), 64'(rst_a));
      check("async_rst_b", 64'(got_b), 64'(rst_b));
      #1 rst_n = 1'b1;

      // Randomized run/request activity against the model.
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 399) == 0) run_b = ~run_b;
         if ($urandom_range(0, 29) == 0)  req_b = ~req_b;
         if ($urandom_range(0, 999) == 0) run_a = ~run_a;
         if ($urandom_range(0, 99) == 0)  req_a = ~req_a;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
